// File: rtl/pipe_pkg.sv
// Shared definitions for the six-stage pipeline sequencer: stage indices,
// decision priority encoding and default bus widths.
package pipe_pkg;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned MODE_W_DEF = 1;
  localparam int unsigned NUM_STAGES = 6;
  localparam int unsigned WAIT_W     = 4;

  localparam int unsigned F = 0;
  localparam int unsigned T = 1;
  localparam int unsigned D = 2;
  localparam int unsigned E = 3;
  localparam int unsigned M = 4;
  localparam int unsigned W = 5;

  typedef enum logic [2:0] {
    NONE,
    MEMWAIT,
    MJMP,
    LOADUSE,
    DJMP,
    TJMP
  } pri_e;

endpackage

// File: rtl/pipe_wait_timer.sv
// Data-memory wait timer: holds m for MEM_WAIT-1 cycles per access; the
// counter holds the wait cycles still owed after the current one.
module pipe_wait_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_start,
  output logic o_busy
);

  localparam logic [WAIT_W-1:0] LOAD_V =
    (MEM_WAIT > 1) ? WAIT_W'(MEM_WAIT - 2) : '0;

  logic [WAIT_W-1:0] r_count;
  logic              r_served;
  logic              w_load;

  // r_served blocks re-arming on the access that just finished its wait
  assign w_load = (MEM_WAIT > 1) && i_start && (r_count == '0) && !r_served;
  assign o_busy = w_load || (r_count != '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count  <= '0;
      r_served <= 1'b0;
    end else begin
      if (w_load) begin
        r_count <= LOAD_V;
      end else if (r_count != '0) begin
        r_count <= r_count - WAIT_W'(1);
      end
      r_served <= w_load | (o_busy & r_served);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: resolves redirects, load-use and memory waits into
// per-stage stall/bubble, tracks stage valid bits and performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned MODE_W   = MODE_W_DEF,
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  t_do_jmp,
  input  logic [PC_W-1:0]       t_target_pc,
  input  logic [MODE_W-1:0]     t_target_mode,
  input  logic                  d_do_jmp,
  input  logic [PC_W-1:0]       d_target_pc,
  input  logic [MODE_W-1:0]     d_target_mode,
  input  logic                  m_do_jmp,
  input  logic [PC_W-1:0]       m_target_pc,
  input  logic [MODE_W-1:0]     m_target_mode,
  input  logic                  load_use,
  input  logic                  m_mem_access,
  output logic                  f_stall,
  output logic                  t_stall,
  output logic                  d_stall,
  output logic                  e_stall,
  output logic                  m_stall,
  output logic                  t_bubble,
  output logic                  d_bubble,
  output logic                  e_bubble,
  output logic                  m_bubble,
  output logic                  w_bubble,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  redirect,
  output logic [PC_W-1:0]       redirect_pc,
  output logic [MODE_W-1:0]     redirect_mode,
  output logic                  mem_busy,
  output logic [CNT_W-1:0]      cnt_cycle,
  output logic [CNT_W-1:0]      cnt_stall,
  output logic [CNT_W-1:0]      cnt_flush
);

  logic [NUM_STAGES-1:0] r_valid;
  logic [NUM_STAGES-1:0] w_valid_next;
  logic [NUM_STAGES-1:0] w_prev;
  logic [NUM_STAGES-1:0] w_stall;
  logic [NUM_STAGES-1:0] w_bub;
  logic                  w_mjmp, w_djmp, w_tjmp, w_lu, w_mem, w_busy;
  pri_e                  w_pri;
  logic                  w_redirect;
  logic [PC_W-1:0]       w_rpc;
  logic [MODE_W-1:0]     w_rmode;
  logic [CNT_W-1:0]      r_cnt_cycle, r_cnt_stall, r_cnt_flush;

  assign w_mjmp = m_do_jmp     & r_valid[M];
  assign w_djmp = d_do_jmp     & r_valid[D];
  assign w_tjmp = t_do_jmp     & r_valid[T];
  assign w_lu   = load_use     & r_valid[D];
  assign w_mem  = m_mem_access & r_valid[M];

  pipe_wait_timer #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .clock   (clock),
    .resetn  (resetn),
    .i_start (w_mem),
    .o_busy  (w_busy)
  );

  // Highest-priority cause wins the cycle
  always_comb begin
    w_pri = NONE;
    if (w_busy)      w_pri = MEMWAIT;
    else if (w_mjmp) w_pri = MJMP;
    else if (w_lu)   w_pri = LOADUSE;
    else if (w_djmp) w_pri = DJMP;
    else if (w_tjmp) w_pri = TJMP;
  end

  always_comb begin
    w_stall    = '0;
    w_bub      = '0;
    w_redirect = 1'b0;
    w_rpc      = '0;
    w_rmode    = '0;
    case (w_pri)
      MEMWAIT: begin
        w_stall[M:F] = '1;
        w_bub[W]     = 1'b1;
      end
      MJMP: begin
        w_bub[M:T] = '1;
        w_redirect = 1'b1;
        w_rpc      = m_target_pc;
        w_rmode    = m_target_mode;
      end
      LOADUSE: begin
        w_stall[D:F] = '1;
        w_bub[E]     = 1'b1;
      end
      DJMP: begin
        w_bub[D:T] = '1;
        w_redirect = 1'b1;
        w_rpc      = d_target_pc;
        w_rmode    = d_target_mode;
      end
      TJMP: begin
        w_bub[T]   = 1'b1;
        w_redirect = 1'b1;
        w_rpc      = t_target_pc;
        w_rmode    = t_target_mode;
      end
      default: ;
    endcase
  end

  // Fetch always sources a valid slot; later stages shift, hold or squash
  always_comb begin
    w_prev       = {r_valid[NUM_STAGES-2:0], 1'b1};
    w_valid_next = '0;
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      if (w_stall[s])    w_valid_next[s] = r_valid[s];
      else if (w_bub[s]) w_valid_next[s] = 1'b0;
      else               w_valid_next[s] = w_prev[s];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid     <= '0;
      r_cnt_cycle <= '0;
      r_cnt_stall <= '0;
      r_cnt_flush <= '0;
    end else begin
      r_valid     <= w_valid_next;
      r_cnt_cycle <= r_cnt_cycle + CNT_W'(1);
      r_cnt_stall <= r_cnt_stall + CNT_W'(w_stall[F]);
      r_cnt_flush <= r_cnt_flush + CNT_W'(w_redirect);
    end
  end

  assign f_stall       = w_stall[F];
  assign t_stall       = w_stall[T];
  assign d_stall       = w_stall[D];
  assign e_stall       = w_stall[E];
  assign m_stall       = w_stall[M];
  assign t_bubble      = w_bub[T];
  assign d_bubble      = w_bub[D];
  assign e_bubble      = w_bub[E];
  assign m_bubble      = w_bub[M];
  assign w_bubble      = w_bub[W];
  assign stage_valid   = r_valid;
  assign redirect      = w_redirect;
  assign redirect_pc   = w_rpc;
  assign redirect_mode = w_rmode;
  assign mem_busy      = w_busy;
  assign cnt_cycle     = r_cnt_cycle;
  assign cnt_stall     = r_cnt_stall;
  assign cnt_flush     = r_cnt_flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MW = 3;

  logic        clock = 1'b0;
  logic        resetn;
  logic        t_do_jmp, d_do_jmp, m_do_jmp, load_use, m_mem_access;
  logic [31:0] t_target_pc, d_target_pc, m_target_pc;
  logic        t_target_mode, d_target_mode, m_target_mode;

  logic        f_stall, t_stall, d_stall, e_stall, m_stall;
  logic        t_bubble, d_bubble, e_bubble, m_bubble, w_bubble;
  logic [5:0]  stage_valid;
  logic        redirect, redirect_mode, mem_busy;
  logic [31:0] redirect_pc, cnt_cycle, cnt_stall, cnt_flush;

  logic        q_fs, q_ts, q_ds, q_es, q_ms, q_tb, q_db, q_eb, q_mb, q_wb;
  logic [5:0]  q_valid;
  logic        q_redirect, q_rmode, q_busy;
  logic [31:0] q_rpc;
  logic [3:0]  q_cyc, q_stl, q_fls;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.PC_W(32), .MODE_W(1), .MEM_WAIT(MW), .CNT_W(32)) dut (
    .clock(clock), .resetn(resetn),
    .t_do_jmp(t_do_jmp), .t_target_pc(t_target_pc), .t_target_mode(t_target_mode),
    .d_do_jmp(d_do_jmp), .d_target_pc(d_target_pc), .d_target_mode(d_target_mode),
    .m_do_jmp(m_do_jmp), .m_target_pc(m_target_pc), .m_target_mode(m_target_mode),
    .load_use(load_use), .m_mem_access(m_mem_access),
    .f_stall(f_stall), .t_stall(t_stall), .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall),
    .t_bubble(t_bubble), .d_bubble(d_bubble), .e_bubble(e_bubble), .m_bubble(m_bubble),
    .w_bubble(w_bubble), .stage_valid(stage_valid), .redirect(redirect),
    .redirect_pc(redirect_pc), .redirect_mode(redirect_mode), .mem_busy(mem_busy),
    .cnt_cycle(cnt_cycle), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush));

  pipe_hazard_ctrl #(.PC_W(32), .MODE_W(1), .MEM_WAIT(MW), .CNT_W(4)) dut4 (
    .clock(clock), .resetn(resetn),
    .t_do_jmp(t_do_jmp), .t_target_pc(t_target_pc), .t_target_mode(t_target_mode),
    .d_do_jmp(d_do_jmp), .d_target_pc(d_target_pc), .d_target_mode(d_target_mode),
    .m_do_jmp(m_do_jmp), .m_target_pc(m_target_pc), .m_target_mode(m_target_mode),
    .load_use(load_use), .m_mem_access(m_mem_access),
    .f_stall(q_fs), .t_stall(q_ts), .d_stall(q_ds), .e_stall(q_es), .m_stall(q_ms),
    .t_bubble(q_tb), .d_bubble(q_db), .e_bubble(q_eb), .m_bubble(q_mb),
    .w_bubble(q_wb), .stage_valid(q_valid), .redirect(q_redirect),
    .redirect_pc(q_rpc), .redirect_mode(q_rmode), .mem_busy(q_busy),
    .cnt_cycle(q_cyc), .cnt_stall(q_stl), .cnt_flush(q_fls));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: stage occupancy, owed wait cycles, event tallies
  logic [5:0]  mv, es, eb, nv;
  int          busy_left = 0;
  bit          served    = 1'b0;
  bit          busy, er, emode;
  logic [31:0] epc, c_cyc, c_stl, c_fls;

  always @(negedge clock) begin
    if (chk_en) begin
      if (!resetn) begin
        mv = '0; busy_left = 0; served = 1'b0;
        c_cyc = '0; c_stl = '0; c_fls = '0;
      end
      if (busy_left == 0 && !served && mv[4] && m_mem_access && MW > 1) begin
        busy_left = MW - 1;
        served    = 1'b1;
      end
      busy = (busy_left > 0);
      es = '0; eb = '0; er = 1'b0; epc = '0; emode = 1'b0;
      if (busy) begin
        es = 6'b011111; eb = 6'b100000;
      end else if (m_do_jmp && mv[4]) begin
        eb = 6'b011110; er = 1'b1; epc = m_target_pc; emode = m_target_mode;
      end else if (load_use && mv[2]) begin
        es = 6'b000111; eb = 6'b001000;
      end else if (d_do_jmp && mv[2]) begin
        eb = 6'b000110; er = 1'b1; epc = d_target_pc; emode = d_target_mode;
      end else if (t_do_jmp && mv[1]) begin
        eb = 6'b000010; er = 1'b1; epc = t_target_pc; emode = t_target_mode;
      end
      chk("stall", {1'b0, m_stall, e_stall, d_stall, t_stall, f_stall}, es);
      chk("bubble", {w_bubble, m_bubble, e_bubble, d_bubble, t_bubble, 1'b0}, eb);
      chk("valid", stage_valid, mv);
      chk("redirect", redirect, er);
      chk("redirect_pc", redirect_pc, epc);
      chk("redirect_mode", redirect_mode, emode);
      chk("mem_busy", mem_busy, busy);
      chk("cnt_cycle", cnt_cycle, c_cyc);
      chk("cnt_stall", cnt_stall, c_stl);
      chk("cnt_flush", cnt_flush, c_fls);
      chk("cnt4", {q_cyc, q_stl, q_fls}, {c_cyc[3:0], c_stl[3:0], c_fls[3:0]});
      if (resetn) begin
        nv[0] = 1'b1;
        for (int s = 1; s < 6; s++)
          nv[s] = es[s] ? mv[s] : (eb[s] ? 1'b0 : mv[s-1]);
        mv = nv;
        if (busy) busy_left--; else served = 1'b0;
        c_cyc = c_cyc + 32'd1;
        c_stl = c_stl + 32'(es[0]);
        c_fls = c_fls + 32'(er);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    t_do_jmp = 0; d_do_jmp = 0; m_do_jmp = 0; load_use = 0; m_mem_access = 0;
  endtask

  task automatic fill(input int n);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k <= 10) chk("fill_valid", stage_valid, (k >= 6) ? 64'd63 : 64'((1 << k) - 1));
    end
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    t_target_pc = '0; d_target_pc = '0; m_target_pc = '0;
    t_target_mode = 0; d_target_mode = 0; m_target_mode = 0;
    chk_en = 1'b1;
    tick(); tick();
    chk("reset_valid", stage_valid, 0);
    chk("reset_cnt", cnt_cycle, 0);
    resetn = 1'b1;

    // Refill after reset, then sibling redirects: d wins over t
    fill(10);
    chk("cycle10", cnt_cycle, 10);
    d_do_jmp = 1; d_target_pc = 32'h40; d_target_mode = 1;
    t_do_jmp = 1; t_target_pc = 32'h80; t_target_mode = 0;
    #1;
    chk("dj_redirect", redirect, 1);
    chk("dj_pc", redirect_pc, 32'h40);
    chk("dj_mode", redirect_mode, 1);
    chk("dj_bubbles", {t_bubble, d_bubble, e_bubble}, 3'b110);
    tick(); idle();
    chk("dj_flush", cnt_flush, 1);

    // Load-use masks a simultaneous d jump, which is then taken next cycle
    tick(); tick(); tick();
    load_use = 1; d_do_jmp = 1;
    #1;
    chk("lu_stall", {f_stall, t_stall, d_stall, e_stall}, 4'b1110);
    chk("lu_ebub", e_bubble, 1);
    chk("lu_noredir", redirect, 0);
    tick(); load_use = 0;
    #1;
    chk("lu_then_dj", {redirect, redirect_mode}, 2'b11);
    chk("lu_then_pc", redirect_pc, 32'h40);
    tick(); idle();
    chk("lu_flush", cnt_flush, 2);
    chk("lu_stallcnt", cnt_stall, 1);

    // Memory wait defers an m redirect by MEM_WAIT-1 cycles
    for (int i = 0; i < 6; i++) tick();
    m_mem_access = 1; m_do_jmp = 1; m_target_pc = 32'h100; m_target_mode = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("mw_busy", mem_busy, 1);
      chk("mw_stall", {f_stall, t_stall, d_stall, e_stall, m_stall, w_bubble}, 6'b111111);
      chk("mw_noredir", redirect, 0);
      tick();
    end
    #1;
    chk("mw_done", mem_busy, 0);
    chk("mw_redir", redirect, 1);
    chk("mw_pc", redirect_pc, 32'h100);
    chk("mw_bub", {t_bubble, d_bubble, e_bubble, m_bubble, w_bubble}, 5'b11110);
    tick(); idle();
    chk("mw_stallcnt", cnt_stall, 3);
    chk("mw_flush", cnt_flush, 3);

    // Reset in the middle of a wait clears everything at once
    for (int i = 0; i < 6; i++) tick();
    m_mem_access = 1;
    #1 chk("rw_busy0", mem_busy, 1);
    tick();
    #1 chk("rw_busy1", mem_busy, 1);
    resetn = 1'b0;
    #1;
    chk("rw_busy", mem_busy, 0);
    chk("rw_valid", stage_valid, 0);
    chk("rw_cnts", {cnt_cycle, cnt_stall, cnt_flush}, 96'd0);
    idle();
    tick(); tick();
    resetn = 1'b1;
    fill(17);
    chk("cyc17", cnt_cycle, 17);
    chk("cyc4_wrap", q_cyc, 1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      tick();
      resetn        = ($urandom_range(0, 399) != 0);
      t_do_jmp      = ($urandom_range(0, 3) == 0);
      d_do_jmp      = ($urandom_range(0, 4) == 0);
      m_do_jmp      = ($urandom_range(0, 5) == 0);
      load_use      = ($urandom_range(0, 4) == 0);
      m_mem_access  = ($urandom_range(0, 4) == 0);
      t_target_pc   = $urandom; d_target_pc = $urandom; m_target_pc = $urandom;
      t_target_mode = 1'($urandom); d_target_mode = 1'($urandom); m_target_mode = 1'($urandom);
    end
    @(negedge clock);
    #1 chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
